// File: rtl/cpu_pkg.sv
// Shared datapath defaults and WB write-data select encoding for the CPU slice.
package cpu_pkg;

    localparam int DW_DEF = 32;
    localparam int AW_DEF = 5;

    typedef enum logic [1:0] {
        REGSEL_ALU = 2'd0,
        REGSEL_HI  = 2'd1,
        REGSEL_LO  = 2'd2,
        REGSEL_RSV = 2'd3
    } regsel_t;

endpackage

// File: rtl/hilo_reg.sv
// HI/LO register pair loaded together by mult/multu; async active-low reset.
module hilo_reg #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] hi_d,
    input  logic [DW-1:0] lo_d,
    output logic [DW-1:0] hi_q,
    output logic [DW-1:0] lo_q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (en) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

endmodule

// File: rtl/ex_wb_stage.sv
// EX->WB pipeline boundary: WB registers, HI/LO, GPIO out, forwarding, retired count.
// Optional GPIO_IN_SYNC_EN: 2-flop synchronizer on gpio_in.
module ex_wb_stage
    import cpu_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall_EX,
    input  logic          regwrite_EX,
    input  logic [1:0]    regsel_EX,
    input  logic          enhilo_EX,
    input  logic          rdrt_EX,
    input  logic          gpio_out_en_EX,
    input  logic          gpio_in_en_EX,
    input  logic [AW-1:0] rd_EX,
    input  logic [AW-1:0] rt_EX,
    input  logic [AW-1:0] rs_EX,
    input  logic [DW-1:0] alu_lo_EX,
    input  logic [DW-1:0] alu_hi_EX,
    input  logic [DW-1:0] readdata1_EX,
    input  logic [DW-1:0] gpio_in,
    output logic          regwrite_WB,
    output logic [AW-1:0] regdest_WB,
    output logic [DW-1:0] writedata_WB,
    output logic [DW-1:0] gpio_out,
    output logic          fwd_rs,
    output logic          fwd_rt,
    output logic [DW-1:0] retired
);

    logic          commit;
    logic [AW-1:0] dest;
    logic [DW-1:0] lo_WB;
    regsel_t       regsel_WB;
    logic          gpio_in_en_WB;
    logic [DW-1:0] hi_q;
    logic [DW-1:0] lo_q;
    logic [DW-1:0] gpio_in_q;

    assign commit = ~stall_EX;
    assign dest   = rdrt_EX ? rt_EX : rd_EX;

`ifdef GPIO_IN_SYNC_EN
    logic [DW-1:0] gpio_s1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gpio_s1   <= '0;
            gpio_in_q <= '0;
        end else begin
            gpio_s1   <= gpio_in;
            gpio_in_q <= gpio_s1;
        end
    end
`else
    assign gpio_in_q = gpio_in;
`endif

    // A stalled edge loads a bubble; dest and lo_WB hold since nothing reads them then.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regwrite_WB   <= 1'b0;
            regdest_WB    <= '0;
            lo_WB         <= '0;
            regsel_WB     <= REGSEL_ALU;
            gpio_in_en_WB <= 1'b0;
        end else if (commit) begin
            regwrite_WB   <= regwrite_EX & (dest != '0);
            regdest_WB    <= dest;
            lo_WB         <= alu_lo_EX;
            regsel_WB     <= regsel_t'(regsel_EX);
            gpio_in_en_WB <= gpio_in_en_EX;
        end else begin
            regwrite_WB   <= 1'b0;
            regsel_WB     <= REGSEL_ALU;
            gpio_in_en_WB <= 1'b0;
        end
    end

    hilo_reg #(
        .DW (DW)
    ) u_hilo (
        .clk  (clk),
        .rst  (rst),
        .en   (commit & enhilo_EX),
        .hi_d (alu_hi_EX),
        .lo_d (alu_lo_EX),
        .hi_q (hi_q),
        .lo_q (lo_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gpio_out <= '0;
        end else if (commit && gpio_out_en_EX) begin
            gpio_out <= readdata1_EX;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired <= '0;
        end else if (commit && (regwrite_EX || enhilo_EX || gpio_out_en_EX)) begin
            retired <= retired + DW'(1);
        end
    end

    // HI/LO are read before this edge's update, so mfhi after mult needs no stall.
    always_comb begin
        writedata_WB = lo_WB;
        if (gpio_in_en_WB) begin
            writedata_WB = gpio_in_q;
        end else begin
            case (regsel_WB)
                REGSEL_HI: writedata_WB = hi_q;
                REGSEL_LO: writedata_WB = lo_q;
                default:   writedata_WB = lo_WB;
            endcase
        end
    end

    assign fwd_rs = regwrite_WB & (regdest_WB == rs_EX);
    assign fwd_rt = regwrite_WB & (regdest_WB == rt_EX);

endmodule

// File: tb/tb_ex_wb_stage.sv
// Scoreboard bench for ex_wb_stage: directed cases plus random EX traffic vs. a reference model.
module tb_ex_wb_stage;

    typedef struct {
        logic        stall;
        logic        rw;
        logic [1:0]  sel;
        logic        hl;
        logic        rdrt;
        logic        gout;
        logic        gin;
        logic [4:0]  rd;
        logic [4:0]  rt;
        logic [4:0]  rs;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [31:0] rd1;
        logic [31:0] gpio;
    } ex_t;

    typedef struct {
        logic        we;
        logic [4:0]  dest;
        logic [31:0] wd;
        logic [31:0] gpio;
        logic [31:0] ret;
        logic        frs;
        logic        frt;
        logic [7:0]  ret8;
    } exp_t;

`ifdef GPIO_IN_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        stall_EX, regwrite_EX, enhilo_EX, rdrt_EX, gpio_out_en_EX, gpio_in_en_EX;
    logic [1:0]  regsel_EX;
    logic [4:0]  rd_EX, rt_EX, rs_EX;
    logic [31:0] alu_lo_EX, alu_hi_EX, readdata1_EX, gpio_in;

    logic        regwrite_WB, fwd_rs, fwd_rt;
    logic [4:0]  regdest_WB;
    logic [31:0] writedata_WB, gpio_out, retired;

    logic        regwrite8, frs8, frt8;
    logic [4:0]  regdest8;
    logic [7:0]  wd8, gpio8, ret8;

    int errors = 0;
    int checks = 0;

    exp_t sb[$];

    // Reference model state: what the WB stage architecturally holds.
    logic        m_we, m_gin;
    logic [4:0]  m_dest;
    logic [1:0]  m_sel;
    logic [31:0] m_wlo, m_hi, m_lo, m_gpio, m_ret, gs1, gs2;
    logic [7:0]  m_ret8;

    ex_wb_stage #(.DW(32), .AW(5)) u_dut (
        .clk(clk), .rst(rst), .stall_EX(stall_EX), .regwrite_EX(regwrite_EX),
        .regsel_EX(regsel_EX), .enhilo_EX(enhilo_EX), .rdrt_EX(rdrt_EX),
        .gpio_out_en_EX(gpio_out_en_EX), .gpio_in_en_EX(gpio_in_en_EX),
        .rd_EX(rd_EX), .rt_EX(rt_EX), .rs_EX(rs_EX), .alu_lo_EX(alu_lo_EX),
        .alu_hi_EX(alu_hi_EX), .readdata1_EX(readdata1_EX), .gpio_in(gpio_in),
        .regwrite_WB(regwrite_WB), .regdest_WB(regdest_WB), .writedata_WB(writedata_WB),
        .gpio_out(gpio_out), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .retired(retired)
    );

    // Narrow instance so the retired counter wrap is reachable in a short run.
    ex_wb_stage #(.DW(8), .AW(5)) u_dut8 (
        .clk(clk), .rst(rst), .stall_EX(stall_EX), .regwrite_EX(regwrite_EX),
        .regsel_EX(regsel_EX), .enhilo_EX(enhilo_EX), .rdrt_EX(rdrt_EX),
        .gpio_out_en_EX(gpio_out_en_EX), .gpio_in_en_EX(gpio_in_en_EX),
        .rd_EX(rd_EX), .rt_EX(rt_EX), .rs_EX(rs_EX), .alu_lo_EX(alu_lo_EX[7:0]),
        .alu_hi_EX(alu_hi_EX[7:0]), .readdata1_EX(readdata1_EX[7:0]), .gpio_in(gpio_in[7:0]),
        .regwrite_WB(regwrite8), .regdest_WB(regdest8), .writedata_WB(wd8),
        .gpio_out(gpio8), .fwd_rs(frs8), .fwd_rt(frt8), .retired(ret8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_we = 0; m_gin = 0; m_dest = 0; m_sel = 0; m_wlo = 0;
        m_hi = 0; m_lo = 0; m_gpio = 0; m_ret = 0; m_ret8 = 0; gs1 = 0; gs2 = 0;
    endtask

    function automatic ex_t nop();
        ex_t e;
        e = '{default: '0};
        return e;
    endfunction

    function automatic ex_t rand_ex();
        ex_t e;
        e.stall = ($urandom_range(0, 3) == 0);
        e.rw    = $urandom_range(0, 1);
        e.sel   = 2'($urandom_range(0, 3));
        e.hl    = ($urandom_range(0, 3) == 0);
        e.rdrt  = $urandom_range(0, 1);
        e.gout  = ($urandom_range(0, 4) == 0);
        e.gin   = ($urandom_range(0, 4) == 0);
        e.rd    = 5'($urandom_range(0, 7));
        e.rt    = 5'($urandom_range(0, 7));
        e.rs    = 5'($urandom_range(0, 7));
        e.lo    = $urandom;
        e.hi    = $urandom;
        e.rd1   = $urandom;
        e.gpio  = ($urandom_range(0, 2) == 0) ? $urandom : gpio_in;
        return e;
    endfunction

    // Drive at negedge, predict the outputs visible this cycle, then advance the model at posedge.
    task automatic issue(input ex_t e);
        exp_t x;
        logic [31:0] gq;
        logic [4:0]  d;
        @(negedge clk);
        rst = 1'b1;
        stall_EX = e.stall; regwrite_EX = e.rw; regsel_EX = e.sel; enhilo_EX = e.hl;
        rdrt_EX = e.rdrt; gpio_out_en_EX = e.gout; gpio_in_en_EX = e.gin;
        rd_EX = e.rd; rt_EX = e.rt; rs_EX = e.rs; alu_lo_EX = e.lo; alu_hi_EX = e.hi;
        readdata1_EX = e.rd1; gpio_in = e.gpio;
        gq = SYNC ? gs2 : e.gpio;
        x.we   = m_we;
        x.dest = m_dest;
        x.wd   = m_gin ? gq : (m_sel == 2'd1) ? m_hi : (m_sel == 2'd2) ? m_lo : m_wlo;
        x.gpio = m_gpio;
        x.ret  = m_ret;
        x.frs  = m_we && (m_dest == e.rs);
        x.frt  = m_we && (m_dest == e.rt);
        x.ret8 = m_ret8;
        sb.push_back(x);
        @(posedge clk);
        gs2 = gs1;
        gs1 = e.gpio;
        if (!e.stall) begin
            d      = e.rdrt ? e.rt : e.rd;
            m_we   = e.rw && (d != 0);
            m_dest = d;
            m_wlo  = e.lo;
            m_sel  = e.sel;
            m_gin  = e.gin;
            if (e.hl) begin
                m_hi = e.hi;
                m_lo = e.lo;
            end
            if (e.gout) m_gpio = e.rd1;
            if (e.rw || e.hl || e.gout) begin
                m_ret  = m_ret + 1;
                m_ret8 = m_ret8 + 1;
            end
        end else begin
            m_we = 0; m_gin = 0; m_sel = 0;
        end
        #1;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check("regwrite_WB", 32'(regwrite_WB), 32'(x.we));
                check("regdest_WB", 32'(regdest_WB), 32'(x.dest));
                check("writedata_WB", writedata_WB, x.wd);
                check("gpio_out", gpio_out, x.gpio);
                check("retired", retired, x.ret);
                check("fwd_rs", 32'(fwd_rs), 32'(x.frs));
                check("fwd_rt", 32'(fwd_rt), 32'(x.frt));
                check("retired8", 32'(ret8), 32'(x.ret8));
            end
        end
    end

    initial begin : driver
        ex_t e;
        rst = 1'b1;
        stall_EX = 0; regwrite_EX = 0; regsel_EX = 0; enhilo_EX = 0; rdrt_EX = 0;
        gpio_out_en_EX = 0; gpio_in_en_EX = 0; rd_EX = 0; rt_EX = 0; rs_EX = 0;
        alu_lo_EX = 0; alu_hi_EX = 0; readdata1_EX = 0; gpio_in = 0;
        model_reset();
        #1 rst = 1'b0;
        #1;
        check("reset regwrite_WB", 32'(regwrite_WB), 32'd0);
        check("reset regdest_WB", 32'(regdest_WB), 32'd0);
        check("reset writedata_WB", writedata_WB, 32'd0);
        check("reset retired", retired, 32'd0);

        // add $5 <- 7, followed by an instruction reading rs = 5
        e = nop(); e.rw = 1; e.rd = 5; e.lo = 32'h7;
        issue(e);
        check("add regwrite", 32'(regwrite_WB), 32'd1);
        check("add regdest", 32'(regdest_WB), 32'd5);
        check("add writedata", writedata_WB, 32'h7);
        e = nop(); e.rs = 5; e.rt = 2;
        issue(e);

        // multu, mfhi $3, mflo $4
        e = nop(); e.hl = 1; e.hi = 32'h1; e.lo = 32'hFFFF_FFFE; e.rd = 7;
        issue(e);
        check("multu regwrite", 32'(regwrite_WB), 32'd0);
        e = nop(); e.rw = 1; e.sel = 2'd1; e.rd = 3;
        issue(e);
        check("mfhi writedata", writedata_WB, 32'h1);
        e = nop(); e.rw = 1; e.sel = 2'd2; e.rd = 4;
        issue(e);
        check("mflo writedata", writedata_WB, 32'hFFFF_FFFE);

        // srl shamt 0 -> GPIO out, then the same while stalled
        e = nop(); e.gout = 1; e.rd1 = 32'hA5A5_0000;
        issue(e);
        check("srl gpio_out", gpio_out, 32'hA5A5_0000);
        e = nop(); e.stall = 1; e.gout = 1; e.rw = 1; e.rd = 6; e.rd1 = 32'h5A5A_FFFF;
        issue(e);
        check("stall gpio_out", gpio_out, 32'hA5A5_0000);
        check("stall regwrite", 32'(regwrite_WB), 32'd0);

        // sra shamt 0 -> read GPIO in into rt = 9 (gpio_in held long enough for the synchronizer)
        e = nop(); e.gpio = 32'h1234;
        issue(e);
        issue(e);
        e.rw = 1; e.gin = 1; e.rt = 9; e.rdrt = 1;
        issue(e);
        check("sra writedata", writedata_WB, 32'h1234);
        check("sra regdest", 32'(regdest_WB), 32'd9);

        // addi to $0: no write, no forward, still retires
        e = nop(); e.rw = 1; e.rdrt = 1; e.rt = 0; e.rd = 8;
        issue(e);
        check("addi r0 regwrite", 32'(regwrite_WB), 32'd0);
        check("addi r0 retired", retired, m_ret);
        e = nop(); e.rs = 0; e.rt = 0;
        issue(e);

        // Mid-run asynchronous reset while a write is in WB
        e = nop(); e.rw = 1; e.rd = 5; e.lo = 32'h55; e.gout = 1; e.rd1 = 32'hDEAD_BEEF;
        issue(e);
        check("pre-reset regwrite", 32'(regwrite_WB), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async reset regwrite_WB", 32'(regwrite_WB), 32'd0);
        check("async reset gpio_out", gpio_out, 32'd0);
        check("async reset retired", retired, 32'd0);
        check("async reset writedata_WB", writedata_WB, 32'd0);
        model_reset();

        for (int unsigned i = 0; i < 900; i++) begin
            issue(rand_ex());
        end
        issue(nop());
        issue(nop());

        @(negedge clk);
        #3;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
